axis_pkt_gen: RTL and testbench

AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

---
 rtl/axis_pkt_gen_if.sv | 25 ++
 rtl/axis_pkt_gen.sv | 219 +++++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_gen_if.sv
// ---------------------------------------------------------------------------
// AXIS_int : minimal AXI4-Stream bundle used by axis_pkt_gen.
//
// Parameter
//   DATA_BYTES : number of byte lanes on tdata (tkeep width).
//
// Signals (all in the clock domain of the module using the bundle)
//   tdata  [8*DATA_BYTES-1:0] : payload, byte 0 on tdata[7:0]
//   tkeep  [DATA_BYTES-1:0]   : byte-valid qualifiers
//   tlast                     : final beat of a packet
//   tvalid                    : beat presented by master
//   tready                    : beat accepted by slave
// ---------------------------------------------------------------------------
interface AXIS_int #(
    parameter int DATA_BYTES = 4
) ();
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport Master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport Slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_pkt_gen.sv
// ---------------------------------------------------------------------------
// axis_pkt_gen : AXI4-Stream test-packet generator.
//
// On a start pulse the run parameters are captured (and clamped) and
// num_pkts packets are streamed back-to-back. Packet p has length
// blen_min + (p mod (blen_max-blen_min+1)); byte k of packet p is (p+k) mod 256.
//
// Parameters
//   MTU_BYTES    : maximum packet byte length
//   NUM_PKTS_LOG : width of the packet-count fields
//   BLEN_W       : derived byte-length field width
//
// Ports
//   clk             in  : clock (also clocks axis_packet_out)
//   sresetn         in  : asynchronous active-low reset
//   start           in  : single-cycle pulse beginning a run (ignored while busy)
//   num_pkts        in  : packets in the run
//   blen_min        in  : smallest packet byte length
//   blen_max        in  : largest packet byte length
//   axis_packet_out mst : packet stream, width from the interface DATA_BYTES
//   busy            out : high while a run is active
//   done            out : one-cycle pulse after the last accepted beat
//   pkts_sent       out : packets completed in the current / last run
//
// Build option
//   AXIS_PKT_GEN_THROTTLE_EN : when defined, a 16-bit LFSR inserts idle
//   cycles between beats; the byte stream itself is unchanged.
// ---------------------------------------------------------------------------
module axis_pkt_gen #(
    parameter  int MTU_BYTES    = 64,
    parameter  int NUM_PKTS_LOG = 8,
    localparam int BLEN_W       = $clog2(MTU_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    sresetn,
    input  logic                    start,
    input  logic [NUM_PKTS_LOG-1:0] num_pkts,
    input  logic [BLEN_W-1:0]       blen_min,
    input  logic [BLEN_W-1:0]       blen_max,
    AXIS_int.Master                 axis_packet_out,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_PKTS_LOG-1:0] pkts_sent
);
    localparam int DATA_BYTES = axis_packet_out.DATA_BYTES;

    if (MTU_BYTES == 0 || NUM_PKTS_LOG == 0 || DATA_BYTES == 0) begin : g_param_check
        $error("axis_pkt_gen: MTU_BYTES, NUM_PKTS_LOG and DATA_BYTES must all be non-zero");
    end

    typedef struct packed {
        logic [8*DATA_BYTES-1:0] data;
        logic [DATA_BYTES-1:0]   keep;
        logic                    last;
    } beat_t;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    // Lower bound: zero-length packets are promoted to one byte, and
    // anything beyond the MTU is cut back to it.
    function automatic logic [BLEN_W-1:0] f_clamp_min(input logic [BLEN_W-1:0] v);
        if (v == '0)
            return BLEN_W'(1);
        if (int'(v) > MTU_BYTES)
            return BLEN_W'(MTU_BYTES);
        return v;
    endfunction

    function automatic logic [BLEN_W-1:0] f_clamp_max(input logic [BLEN_W-1:0] v,
                                                      input logic [BLEN_W-1:0] mn);
        logic [BLEN_W-1:0] t;
        t = (int'(v) > MTU_BYTES) ? BLEN_W'(MTU_BYTES) : v;
        if (t < mn)
            t = mn;
        return t;
    endfunction

    // Builds the beat starting at byte offset k of packet p (length blen).
    // Lanes past the end of the packet are zero with tkeep cleared.
    function automatic beat_t f_beat(input logic [NUM_PKTS_LOG-1:0] p,
                                     input logic [BLEN_W-1:0]       k,
                                     input logic [BLEN_W-1:0]       blen);
        beat_t b;
        int    idx;
        b = '0;
        for (int j = 0; j < DATA_BYTES; j++) begin
            idx = int'(k) + j;
            if (idx < int'(blen)) begin
                b.data[8*j +: 8] = 8'(int'(p) + idx);
                b.keep[j]        = 1'b1;
            end
        end
        b.last = (int'(k) + DATA_BYTES) >= int'(blen);
        return b;
    endfunction

    state_t                  r_state, w_state_nxt;
    logic [NUM_PKTS_LOG-1:0] r_num_pkts;
    logic [BLEN_W-1:0]       r_blen_min, r_blen_max;
    logic [NUM_PKTS_LOG-1:0] r_pkt;
    logic [BLEN_W-1:0]       r_off;
    logic [BLEN_W-1:0]       r_blen;
    beat_t                   r_beat;
    logic                    r_have;       // a beat is loaded in r_beat
    logic [NUM_PKTS_LOG-1:0] r_pkts_sent;
    logic                    r_busy, r_done;

    logic                    w_tvalid, w_accept, w_last_pkt, w_run_end;
    logic                    w_start_run, w_start_zero;
    logic                    w_busy_nxt, w_done_nxt;
    logic [BLEN_W-1:0]       w_min_c, w_max_c, w_off_nxt, w_blen_nxt;

    assign w_min_c      = f_clamp_min(blen_min);
    assign w_max_c      = f_clamp_max(blen_max, w_min_c);
    assign w_start_run  = (r_state == S_IDLE) && start && (num_pkts != '0);
    assign w_start_zero = (r_state == S_IDLE) && start && (num_pkts == '0);
    assign w_accept     = w_tvalid && axis_packet_out.tready;
    assign w_last_pkt   = ({1'b0, r_pkt} + (NUM_PKTS_LOG+1)'(1)) == {1'b0, r_num_pkts};
    assign w_run_end    = w_accept && r_beat.last && w_last_pkt;
    assign w_off_nxt    = r_off + BLEN_W'(DATA_BYTES);
    // Length sequence wraps max -> min, giving the modulo pattern without a divider.
    assign w_blen_nxt   = (r_blen >= r_blen_max) ? r_blen_min : r_blen + BLEN_W'(1);

`ifdef AXIS_PKT_GEN_THROTTLE_EN
    logic [15:0] r_lfsr;
    logic        r_shown;   // beat was offered but not taken; must stay valid

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            r_lfsr  <= 16'hACE1;
            r_shown <= 1'b0;
        end else begin
            // x^16 + x^14 + x^13 + x^11 + 1, maximal length
            r_lfsr  <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_shown <= w_tvalid && !axis_packet_out.tready;
        end
    end

    assign w_tvalid = r_have && (r_lfsr[0] || r_shown);
`else
    assign w_tvalid = r_have;
`endif

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_run) w_state_nxt = S_SEND;
            S_SEND:  if (w_run_end)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // An empty run is busy for exactly the cycle in which done pulses.
        w_busy_nxt = (w_state_nxt == S_SEND) || w_start_zero;
        w_done_nxt = w_run_end || w_start_zero;
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            r_num_pkts  <= '0;
            r_blen_min  <= '0;
            r_blen_max  <= '0;
            r_pkt       <= '0;
            r_off       <= '0;
            r_blen      <= '0;
            r_beat      <= '0;
            r_have      <= 1'b0;
            r_pkts_sent <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_start_run || w_start_zero) begin
                r_num_pkts  <= num_pkts;
                r_blen_min  <= w_min_c;
                r_blen_max  <= w_max_c;
                r_pkts_sent <= '0;
            end
            if (w_start_run) begin
                r_pkt  <= '0;
                r_off  <= '0;
                r_blen <= w_min_c;
                r_beat <= f_beat('0, '0, w_min_c);
                r_have <= 1'b1;
            end else if (w_accept) begin
                if (r_beat.last) begin
                    r_pkts_sent <= r_pkts_sent + NUM_PKTS_LOG'(1);
                    if (w_last_pkt) begin
                        r_have <= 1'b0;
                        r_beat <= '0;
                    end else begin
                        r_pkt  <= r_pkt + NUM_PKTS_LOG'(1);
                        r_off  <= '0;
                        r_blen <= w_blen_nxt;
                        r_beat <= f_beat(r_pkt + NUM_PKTS_LOG'(1), '0, w_blen_nxt);
                    end
                end else begin
                    r_off  <= w_off_nxt;
                    r_beat <= f_beat(r_pkt, w_off_nxt, r_blen);
                end
            end
        end
    end

    assign axis_packet_out.tdata  = r_beat.data;
    assign axis_packet_out.tkeep  = r_beat.keep;
    assign axis_packet_out.tlast  = r_beat.last;
    assign axis_packet_out.tvalid = w_tvalid;
    assign busy                   = r_busy;
    assign done                   = r_done;
    assign pkts_sent              = r_pkts_sent;

endmodule

// File: tb/tb_axis_pkt_gen.sv
module tb_axis_pkt_gen;
    localparam int MTU = 64;
    localparam int NPL = 8;
    localparam int BW  = $clog2(MTU + 1);

    logic           clk      = 1'b0;
    logic           sresetn  = 1'b0;
    logic           start    = 1'b0;
    logic [NPL-1:0] num_pkts = '0;
    logic [BW-1:0]  blen_min = '0;
    logic [BW-1:0]  blen_max = '0;
    logic           busy;
    logic           done;
    logic [NPL-1:0] pkts_sent;

    AXIS_int #(.DATA_BYTES(4)) u_axis ();

    axis_pkt_gen #(.MTU_BYTES(MTU), .NUM_PKTS_LOG(NPL)) dut (
        .clk             (clk),
        .sresetn         (sresetn),
        .start           (start),
        .num_pkts        (num_pkts),
        .blen_min        (blen_min),
        .blen_max        (blen_max),
        .axis_packet_out (u_axis),
        .busy            (busy),
        .done            (done),
        .pkts_sent       (pkts_sent)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Pulse start with the given run parameters; returns at the first
    // sampling point after the start edge.
    task automatic kick(input int n, input int mn, input int mx);
        @(negedge clk);
        num_pkts = NPL'(n);
        blen_min = BW'(mn);
        blen_max = BW'(mx);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Wait (bounded) for a valid beat, check it, then step one cycle.
    task automatic expect_beat(input string tag, input logic [31:0] d,
                               input logic [3:0] k, input logic l);
        int w = 0;
        while (u_axis.tvalid !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_val({tag, ".vld"},  32'(u_axis.tvalid), 32'd1);
        check_val({tag, ".data"}, u_axis.tdata, d);
        check_val({tag, ".keep"}, 32'(u_axis.tkeep), 32'(k));
        check_val({tag, ".last"}, 32'(u_axis.tlast), 32'(l));
        @(negedge clk);
    endtask

    // Full run with a reference model of lengths and bytes.
    task automatic run_pkts(input string tag, input int n, input int mn, input int mx, input bit stall);
        logic [7:0] got_b[$];
        int         got_len[$];
        int         cur = 0, idle = 0, cyc = 0, errs = 0, pos = 0;
        int         emn, emx, elen;
        bit         fin = 1'b0;
        kick(n, mn, mx);
        while (!fin && cyc < 20000) begin
            u_axis.tready = stall ? ((cyc % 3) != 1) : 1'b1;
            if (u_axis.tvalid && u_axis.tready) begin
                if (!u_axis.tlast && u_axis.tkeep != 4'hF) errs++;
                for (int j = 0; j < 4; j++) begin
                    if (u_axis.tkeep[j]) begin
                        got_b.push_back(u_axis.tdata[8*j +: 8]);
                        cur++;
                    end else if (u_axis.tdata[8*j +: 8] != 8'h00) begin
                        errs++;
                    end
                end
                if (u_axis.tlast) begin
                    got_len.push_back(cur);
                    cur = 0;
                end
            end else if (busy && !u_axis.tvalid) begin
                idle++;
            end
            if (done) fin = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        u_axis.tready = 1'b1;
        check_val({tag, ".done"}, 32'(fin), 32'd1);
        emn = (mn == 0) ? 1 : mn;
        if (emn > MTU) emn = MTU;
        emx = (mx > MTU) ? MTU : mx;
        if (emx < emn) emx = emn;
        for (int p = 0; p < n; p++) begin
            elen = emn + (p % (emx - emn + 1));
            if (p < got_len.size() && got_len[p] != elen) errs++;
            for (int k = 0; k < elen; k++) begin
                if (pos >= got_b.size() || got_b[pos] !== 8'((p + k) % 256)) errs++;
                pos++;
            end
        end
        check_val({tag, ".npkt"},   32'(got_len.size()), 32'(n));
        check_val({tag, ".nbytes"}, 32'(got_b.size()), 32'(pos));
        check_val({tag, ".errs"},   32'(errs), 32'd0);
        check_val({tag, ".sent"},   32'(pkts_sent), 32'(n));
`ifdef AXIS_PKT_GEN_THROTTLE_EN
        check_val({tag, ".idles"},  32'(idle > 0), 32'd1);
`else
        check_val({tag, ".idles"},  32'(idle), 32'd0);
`endif
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        u_axis.tready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        check_val("rst.tvalid", 32'(u_axis.tvalid), 32'd0);
        check_val("rst.tdata",  u_axis.tdata, 32'd0);
        check_val("rst.tkeep",  32'(u_axis.tkeep), 32'd0);
        check_val("rst.tlast",  32'(u_axis.tlast), 32'd0);
        check_val("rst.busy",   32'(busy), 32'd0);
        check_val("rst.done",   32'(done), 32'd0);
        check_val("rst.sent",   32'(pkts_sent), 32'd0);
        sresetn = 1'b1;
        @(negedge clk);

        // one 5-byte packet
        kick(1, 5, 5);
`ifndef AXIS_PKT_GEN_THROTTLE_EN
        check_val("t1.latency", 32'(u_axis.tvalid), 32'd1);
`endif
        check_val("t1.busy", 32'(busy), 32'd1);
        expect_beat("t1.b0", 32'h03020100, 4'hF, 1'b0);
        expect_beat("t1.b1", 32'h00000004, 4'h1, 1'b1);
        check_val("t1.done",   32'(done), 32'd1);
        check_val("t1.busy_f", 32'(busy), 32'd0);
        check_val("t1.tvalid", 32'(u_axis.tvalid), 32'd0);
        check_val("t1.sent",   32'(pkts_sent), 32'd1);
        @(negedge clk);
        check_val("t1.done_1c", 32'(done), 32'd0);

        // three packets 4..5 bytes; inputs scrambled after start
        kick(3, 4, 5);
        num_pkts = '0;
        blen_min = BW'(9);
        blen_max = BW'(9);
        expect_beat("t2.p0",  32'h03020100, 4'hF, 1'b1);
        expect_beat("t2.p1a", 32'h04030201, 4'hF, 1'b0);
        expect_beat("t2.p1b", 32'h00000005, 4'h1, 1'b1);
        expect_beat("t2.p2",  32'h05040302, 4'hF, 1'b1);
        check_val("t2.done", 32'(done), 32'd1);
        check_val("t2.sent", 32'(pkts_sent), 32'd3);

        // back-pressure on beat 1 of a 12-byte packet
        kick(1, 12, 12);
        expect_beat("t3.b0", 32'h03020100, 4'hF, 1'b0);
        u_axis.tready = 1'b0;
        for (int w = 0; w < 50 && u_axis.tvalid !== 1'b1; w++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_val("t3.hold_vld",  32'(u_axis.tvalid), 32'd1);
            check_val("t3.hold_data", u_axis.tdata, 32'h07060504);
            check_val("t3.hold_last", 32'(u_axis.tlast), 32'd0);
            @(negedge clk);
        end
        u_axis.tready = 1'b1;
        expect_beat("t3.b1", 32'h07060504, 4'hF, 1'b0);
        expect_beat("t3.b2", 32'h0B0A0908, 4'hF, 1'b1);
        check_val("t3.done", 32'(done), 32'd1);
        check_val("t3.sent", 32'(pkts_sent), 32'd1);

        // empty run
        kick(0, 5, 5);
        check_val("t4.tvalid", 32'(u_axis.tvalid), 32'd0);
        check_val("t4.done",   32'(done), 32'd1);
        check_val("t4.busy",   32'(busy), 32'd1);
        check_val("t4.sent",   32'(pkts_sent), 32'd0);
        @(negedge clk);
        check_val("t4.done_1c", 32'(done), 32'd0);
        check_val("t4.busy_1c", 32'(busy), 32'd0);
        check_val("t4.tvalid2", 32'(u_axis.tvalid), 32'd0);

        // clamping: min 0 -> 1, max beyond MTU (largest encodable) -> 64
        run_pkts("t4c", 66, 0, 127, 1'b0);

        // irregular tready
        run_pkts("t5", 5, 3, 9, 1'b1);

        // reset in the middle of a packet
        kick(3, 8, 8);
        expect_beat("t6.p0a", 32'h03020100, 4'hF, 1'b0);
        expect_beat("t6.p0b", 32'h07060504, 4'hF, 1'b1);
        check_val("t6.sent1", 32'(pkts_sent), 32'd1);
        expect_beat("t6.p1a", 32'h04030201, 4'hF, 1'b0);
        sresetn = 1'b0;
        #1;
        check_val("t6.rst_vld",  32'(u_axis.tvalid), 32'd0);
        check_val("t6.rst_last", 32'(u_axis.tlast), 32'd0);
        check_val("t6.rst_busy", 32'(busy), 32'd0);
        check_val("t6.rst_sent", 32'(pkts_sent), 32'd0);
        @(negedge clk);
        sresetn = 1'b1;
        kick(1, 5, 5);
        expect_beat("t6.n0", 32'h03020100, 4'hF, 1'b0);
        expect_beat("t6.n1", 32'h00000004, 4'h1, 1'b1);
        check_val("t6.done", 32'(done), 32'd1);

        // ten packets 1..64 bytes
        run_pkts("t7", 10, 1, 64, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
